// File: rtl/bcd_convert_n.sv
// Sequential binary-to-BCD converter using shift-add-3 (double dabble),
// one input bit per clock. Produces DIGITS BCD nibbles with optional
// leading-zero blanking (4'hF = blank) and an exact overflow flag.
module bcd_convert_n #(
  parameter int WIDTH    = 14,
  parameter int DIGITS   = 4,
  parameter bit BLANK_LZ = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  start,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [4*DIGITS-1:0]   digits
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] CONV   = 2'd1;
  localparam logic [1:0] FINISH = 2'd2;

  logic [1:0]       state;
  logic [BW-1:0]    bcd;
  logic [WIDTH-1:0] bin;
  logic [CW-1:0]    cnt;
  logic             ovf;
  logic [BW-1:0]    bcd_adj;

  // Add 3 to every nibble that is 5 or more, so the following doubling
  // carries correctly into the next decimal digit.
  function automatic logic [BW-1:0] add3(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic [3:0]    nib;
    r = b;
    for (int i = 0; i < DIGITS; i++) begin
      nib = b[4*i +: 4];
      if (nib >= 4'd5) r[4*i +: 4] = nib + 4'd3;
    end
    return r;
  endfunction

  // Replace zero digits above the most significant non-zero digit with
  // 4'hF; digit 0 always stays visible so a zero result reads as ...F0.
  function automatic logic [BW-1:0] blank_lz(input logic [BW-1:0] b);
    logic [BW-1:0] r;
    logic          lead;
    r    = b;
    lead = 1'b1;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lead && (b[4*i +: 4] == 4'd0)) r[4*i +: 4] = 4'hF;
      else lead = 1'b0;
    end
    return r;
  endfunction

  // Nibble correction feeding the shift in CONV.
  always_comb begin
    bcd_adj = add3(bcd);
  end

  assign ready = (state == IDLE);

  // Control FSM, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      bcd      <= '0;
      bin      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
      done     <= 1'b0;
      overflow <= 1'b0;
      digits   <= '1;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bcd   <= '0;
            bin   <= value;
            cnt   <= CW'(WIDTH);
            ovf   <= 1'b0;
            state <= CONV;
          end
        end
        CONV: begin
          // A carry out of the top digit means the value needs more
          // than DIGITS digits; it is remembered until FINISH.
          ovf <= ovf | bcd_adj[BW-1];
          bcd <= {bcd_adj[BW-2:0], bin[WIDTH-1]};
          bin <= {bin[WIDTH-2:0], 1'b0};
          cnt <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= FINISH;
        end
        FINISH: begin
          done  <= 1'b1;
          state <= IDLE;
          if (ovf) begin
            overflow <= 1'b1;
            digits   <= '1;
          end else begin
            overflow <= 1'b0;
            digits   <= BLANK_LZ ? blank_lz(bcd) : bcd;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
